// File: rtl/subtrator_serial_8bits_pkg.sv
// subtrator_pkg: shared state encoding, default width and counter sizing for the serial subtractor.
package subtrator_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 7;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);
endpackage

// File: rtl/subtrator_serial_8bits_if.sv
// subtrator_serial_8bits_if: request/response bundle of the serial subtractor.
interface subtrator_serial_8bits_if
    import subtrator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] S1;
    logic [WIDTH-1:0] S2;
    logic             B_in;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   resultado;
    logic             B_out;
    logic             ovf;

    modport master (output start, S1, S2, B_in, input busy, done, resultado, B_out, ovf);
    modport slave  (input start, S1, S2, B_in, output busy, done, resultado, B_out, ovf);
endinterface

// File: rtl/subtrator_completo_1bit.sv
// subtrator_completo_1bit: combinational full subtractor, d = a - b - bw_in.
module subtrator_completo_1bit (
    input  logic a,
    input  logic b,
    input  logic bw_in,
    output logic d,
    output logic bw_out
);
    assign d      = a ^ b ^ bw_in;
    assign bw_out = (~a & b) | (~(a ^ b) & bw_in);
endmodule

// File: rtl/subtrator_serial_8bits.sv
// subtrator_serial_8bits: bit-serial S1 - S2 - B_in, one bit per clock with start/busy/done.
// Signed overflow output is built only when SUBTRATOR_SERIAL_OVF_EN is defined.
module subtrator_serial_8bits
    import subtrator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    subtrator_serial_8bits_if.slave  bus
);
    localparam int CW = cnt_w(WIDTH);

    state_t           st_q, st_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic             bw_q, bw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   res_q, res_d;
    logic             bo_q, bo_d;
    logic             d, bw_n;
`ifdef SUBTRATOR_SERIAL_OVF_EN
    logic             sa_q, sa_d, sb_q, sb_d, ovf_q, ovf_d;
`endif

    subtrator_completo_1bit u_fs (
        .a      (a_q[0]),
        .b      (b_q[0]),
        .bw_in  (bw_q),
        .d      (d),
        .bw_out (bw_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= ST_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            bw_q  <= 1'b0;
            cnt_q <= '0;
            res_q <= '0;
            bo_q  <= 1'b0;
`ifdef SUBTRATOR_SERIAL_OVF_EN
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            ovf_q <= 1'b0;
`endif
        end else begin
            st_q  <= st_d;
            a_q   <= a_d;
            b_q   <= b_d;
            r_q   <= r_d;
            bw_q  <= bw_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
            bo_q  <= bo_d;
`ifdef SUBTRATOR_SERIAL_OVF_EN
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            ovf_q <= ovf_d;
`endif
        end
    end

    // SUB spends WIDTH cycles on bits, then one more to publish the result
    always_comb begin
        st_d  = st_q;
        a_d   = a_q;
        b_d   = b_q;
        r_d   = r_q;
        bw_d  = bw_q;
        cnt_d = cnt_q;
        res_d = res_q;
        bo_d  = bo_q;
`ifdef SUBTRATOR_SERIAL_OVF_EN
        sa_d  = sa_q;
        sb_d  = sb_q;
        ovf_d = ovf_q;
`endif
        case (st_q)
            ST_IDLE: if (bus.start) begin
                a_d   = bus.S1;
                b_d   = bus.S2;
                bw_d  = bus.B_in;
                cnt_d = '0;
                st_d  = ST_SUB;
`ifdef SUBTRATOR_SERIAL_OVF_EN
                sa_d  = bus.S1[WIDTH-1];
                sb_d  = bus.S2[WIDTH-1];
`endif
            end
            ST_SUB: if (cnt_q == CW'(WIDTH)) begin
                res_d = {bw_q, r_q};
                bo_d  = bw_q;
                st_d  = ST_DONE;
`ifdef SUBTRATOR_SERIAL_OVF_EN
                ovf_d = (sa_q != sb_q) & (r_q[WIDTH-1] != sa_q);
`endif
            end else begin
                r_d   = {d, r_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bw_d  = bw_n;
                cnt_d = cnt_q + 1'b1;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    assign bus.busy      = (st_q == ST_SUB);
    assign bus.done      = (st_q == ST_DONE);
    assign bus.resultado = res_q;
    assign bus.B_out     = bo_q;
`ifdef SUBTRATOR_SERIAL_OVF_EN
    assign bus.ovf       = ovf_q;
`else
    assign bus.ovf       = 1'b0;
`endif
endmodule

// File: tb/tb_subtrator_serial_8bits.sv
// tb_subtrator_serial_8bits: directed and random checks of the serial subtractor against an arithmetic model.
module tb_subtrator_serial_8bits;
    import subtrator_pkg::*;

    localparam int W = DEF_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    subtrator_serial_8bits_if #(.WIDTH(W)) bus ();

    subtrator_serial_8bits #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input bit pulse);
        int         k;
        int         extra;
        int         sd;
        logic [W:0] er;
        logic       eo;
        er = (W+1)'(a) - (W+1)'(b) - (W+1)'(bin);
        sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
        eo = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
`ifndef SUBTRATOR_SERIAL_OVF_EN
        eo = 1'b0;
`endif
        @(negedge clk);
        bus.start = 1'b1;
        bus.S1 = a;
        bus.S2 = b;
        bus.B_in = bin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.S1 = W'($urandom);
        bus.S2 = W'($urandom);
        bus.B_in = 1'($urandom);
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        k = 0;
        while (!bus.done && k < 20) begin
            if (pulse) bus.start = (k + 1 == 3) || (k + 1 == 5);
            @(posedge clk);
            #1;
            k++;
        end
        bus.start = 1'b0;
        chk("done_latency", 32'(k), 32'd8);
        chk("resultado", 32'(bus.resultado), 32'(er));
        chk("B_out", 32'(bus.B_out), 32'(er[W]));
        chk("ovf", 32'(bus.ovf), 32'(eo));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        if (pulse) begin
            extra = 0;
            repeat (12) begin
                @(posedge clk);
                #1;
                extra += int'(bus.done);
            end
            chk("extra_done", 32'(extra), 32'd0);
            chk("resultado_hold", 32'(bus.resultado), 32'(er));
        end else begin
            @(posedge clk);
        end
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.S1 = '0;
        bus.S2 = '0;
        bus.B_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resultado", 32'(bus.resultado), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_B_out", 32'(bus.B_out), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(7'd100, 7'd37, 1'b0, 1'b0);
        run_op(7'd5, 7'd9, 1'b1, 1'b0);
        run_op(7'd0, 7'd0, 1'b1, 1'b0);
        run_op(7'd127, 7'd127, 1'b0, 1'b0);
        run_op(7'h55, 7'h2A, 1'b0, 1'b1);

        @(negedge clk);
        bus.start = 1'b1;
        bus.S1 = 7'd90;
        bus.S2 = 7'd3;
        bus.B_in = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_resultado", 32'(bus.resultado), 32'd0);
        chk("abort_B_out", 32'(bus.B_out), 32'd0);
        chk("abort_ovf", 32'(bus.ovf), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            n += int'(bus.done);
        end
        chk("abort_no_done", 32'(n), 32'd0);
        run_op(7'd90, 7'd3, 1'b0, 1'b0);

        run_op(7'h40, 7'h01, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
